// File: rtl/baby_alu_pkg.sv
// Shared constants for the baby_alu accumulator datapath.
package baby_alu_pkg;

    // Opcode class field, opcode[3:2]
    localparam logic [1:0] CLS_SYSTEM = 2'b00;
    localparam logic [1:0] CLS_MATH   = 2'b01;
    localparam logic [1:0] CLS_LOGIC  = 2'b10;

    // Function field, opcode[1:0]
    localparam logic [1:0] FN_NOOP  = 2'b00;
    localparam logic [1:0] FN_RESET = 2'b01;
    localparam logic [1:0] FN_ADD   = 2'b01;
    localparam logic [1:0] FN_AND   = 2'b01;

    // Full opcodes
    localparam logic [3:0] OP_NOOP  = {CLS_SYSTEM, FN_NOOP};
    localparam logic [3:0] OP_RESET = {CLS_SYSTEM, FN_RESET};
    localparam logic [3:0] OP_ADD   = {CLS_MATH,   FN_ADD};
    localparam logic [3:0] OP_AND   = {CLS_LOGIC,  FN_AND};

endpackage

// File: rtl/alu_adder.sv
// Ripple-carry adder built from a chain of full adders, carry-in tied low.
module alu_adder
    import baby_alu_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] cy;

    assign cy[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        // One full-adder stage: sum bit and ripple carry into the next stage
        assign sum[i]   = a[i] ^ b[i] ^ cy[i];
        assign cy[i+1]  = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end

    assign cout = cy[WIDTH];

endmodule

// File: rtl/baby_alu.sv
// Two-operand accumulator ALU: combines operand A with the accumulator
// under a 4-bit opcode; the selected result is written back every edge.
module baby_alu
    import baby_alu_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] acc,
    output logic             carry
);

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] and_res;
    logic [WIDTH-1:0] chan [16];

    // B is a reserved port with no internal function
    logic unused_b;
    assign unused_b = ^B;

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (acc),
        .b    (A),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign and_res = acc & A;

    // 16-way opcode-indexed result mux; unused channels read as zero,
    // so any undefined opcode behaves like RESET
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            chan[i] = '0;
        end
        chan[OP_NOOP]  = acc;
        chan[OP_RESET] = '0;
        chan[OP_ADD]   = add_sum;
        chan[OP_AND]   = and_res;
    end

    assign C     = chan[opcode];
    assign carry = (opcode == OP_ADD) & add_cout;

    // Accumulator: async clear, otherwise captures the selected result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= C;
        end
    end

endmodule

// File: tb/tb_baby_alu.sv
// Directed bench for baby_alu (WIDTH = 2) with a behavioural accumulator model.
module tb_baby_alu;

    localparam int W   = 2;
    localparam int MOD = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   opcode;
    logic [W-1:0] C;
    logic [W-1:0] acc;
    logic         carry;

    int  n_checks;
    int  n_errors;
    int  model_acc;
    bit  chk_en;
    bit  rand_b;

    baby_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .opcode (opcode),
        .C      (C),
        .acc    (acc),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of one operation, from the opcode table with plain arithmetic
    function automatic int model_result(input int op, input int a, input int ac);
        case (op)
            0:       return ac;
            1:       return 0;
            5:       return (ac + a) % MOD;
            9:       return ac & a;
            default: return 0;
        endcase
    endfunction

    function automatic int model_carry(input int op, input int a, input int ac);
        return (op == 5 && (ac + a) >= MOD) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model accumulator tracks the DUT register
    always @(posedge clk or posedge rst) begin
        if (rst) model_acc = 0;
        else     model_acc = model_result(int'(opcode), int'(A), model_acc);
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_acc",   {6'b0, acc}, 8'(model_acc));
            check("cmp_c",     {6'b0, C},   8'(model_result(int'(opcode), int'(A), model_acc)));
            check("cmp_carry", {7'b0, carry}, 8'(model_carry(int'(opcode), int'(A), model_acc)));
        end
    end

    // Present one operation (called at posedge+1); negative expectations skip the literal check
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a,
                         input int exp_c, input int exp_cy, input int exp_acc);
        opcode = op;
        A      = a;
        if (rand_b) B = W'($urandom_range(0, MOD - 1));
        #2;
        if (rand_b) B = W'($urandom_range(0, MOD - 1));
        @(negedge clk);
        if (exp_c >= 0)  check("lit_c",     {6'b0, C},     8'(exp_c));
        if (exp_cy >= 0) check("lit_carry", {7'b0, carry}, 8'(exp_cy));
        @(posedge clk);
        #1;
        if (exp_acc >= 0) check("lit_acc", {6'b0, acc}, 8'(exp_acc));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        rand_b   = 1'b0;
        rst      = 1'b1;
        opcode   = 4'b0000;
        A        = '0;
        B        = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_acc", {6'b0, acc}, 8'd0);
        check("reset_c",   {6'b0, C},   8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        for (int pass = 0; pass < 2; pass++) begin
            rand_b = (pass == 1);

            // Load acc = 11, then pulse reset mid-cycle
            do_op(4'b0001, 2'b00, 0, 0, 0);
            do_op(4'b0101, 2'b11, 3, 0, 3);
            opcode = 4'b0000;
            A      = 2'b00;
            #2;
            rst = 1'b1;
            #1;
            check("async_rst_acc", {6'b0, acc}, 8'd0);
            @(negedge clk);
            #2;
            rst = 1'b0;
            @(posedge clk);
            #1;
            do_op(4'b0000, 2'b00, 0, 0, 0);
            do_op(4'b0000, 2'b00, 0, 0, 0);

            // Interleaved ADD / NOOP
            do_op(4'b0101, 2'b01, 1, 0, 1);
            do_op(4'b0000, 2'b01, 1, 0, 1);
            do_op(4'b0101, 2'b01, 2, 0, 2);
            do_op(4'b0000, 2'b00, 2, 0, 2);
            do_op(4'b0101, 2'b01, 3, 0, 3);

            // RESET, ADD 11, AND 10
            do_op(4'b0001, 2'b10, 0, 0, 0);
            do_op(4'b0101, 2'b11, 3, 0, 3);
            do_op(4'b1001, 2'b10, 2, 0, 2);

            // Held ADD wraps; carry only on the 11 -> 00 cycle
            do_op(4'b0001, 2'b00, 0, 0, 0);
            do_op(4'b0101, 2'b01, 1, 0, 1);
            do_op(4'b0101, 2'b01, 2, 0, 2);
            do_op(4'b0101, 2'b01, 3, 0, 3);
            do_op(4'b0101, 2'b01, 0, 1, 0);
            do_op(4'b0101, 2'b01, 1, 0, 1);
            do_op(4'b0101, 2'b01, 2, 0, 2);

            // Unused opcodes clear; AND never produces carry
            do_op(4'b0110, 2'b00, 0, 0, 0);
            do_op(4'b0101, 2'b11, 3, 0, 3);
            do_op(4'b1111, 2'b11, 0, 0, 0);
            do_op(4'b0101, 2'b10, 2, 0, 2);
            do_op(4'b1001, 2'b11, 2, 0, 2);
            do_op(4'b0100, 2'b11, 0, 0, 0);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
